// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered opcode decode with valid/ready intake, stall/flush and multi-cycle hold-off
module ctrl_decode_stage #(
   parameter int OPW      = 5,
   parameter int ALUOPW   = 5,
   parameter int DIV_LAT  = 4,
   parameter int LOAD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPW-1:0]    opcode,
   input  logic              op_valid,
   output logic              in_ready,
   input  logic              stall,
   input  logic              flush,
   output logic              ex_valid,
   output logic              pc_src,
   output logic              demux,
   output logic              reg_write,
   output logic              alu_1st_src,
   output logic              mem_write,
   output logic              mem_read,
   output logic              br_or_jump,
   output logic              optr_inst,
   output logic              illegal,
   output logic [ALUOPW-1:0] alu_op,
   output logic [1:0]        mem2reg
);
   localparam int MAXL = (DIV_LAT > LOAD_LAT) ? DIV_LAT : LOAD_LAT;
   localparam int CW   = $clog2(MAXL + 1);
   typedef enum logic {RUN, WAIT} state_t;
   typedef struct packed {
      logic              pc_src;
      logic              demux;
      logic              reg_write;
      logic              mem_write;
      logic              mem_read;
      logic              br_or_jump;
      logic              optr_inst;
      logic              illegal;
      logic [ALUOPW-1:0] alu_op;
      logic [1:0]        mem2reg;
   } ctl_t;
   localparam ctl_t BUB = '{alu_op: ALUOPW'(13), default: '0};
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ex_valid_q, ex_valid_d;
   logic          alu1_q, alu1_d;
   ctl_t          ctl_q, ctl_d, dec;
   logic [4:0]    lo;
   logic [ALUOPW-1:0] alu;
   logic          legal, accept, is_div, is_load, is_optr, is_optri;
   assign in_ready = !rst && state_q == RUN && !stall && !flush;
   assign accept   = op_valid && in_ready;
   // decode: upper opcode bits must be zero, low five bits pick the operation
   always_comb begin
      lo    = opcode[4:0];
      legal = (opcode >> 5) == '0;
      alu   = ALUOPW'(13);
      case (lo)
         5'd3, 5'd14:                       alu = ALUOPW'(0);
         5'd4, 5'd15:                       alu = ALUOPW'(1);
         5'd5:                              alu = ALUOPW'(2);
         5'd6:                              alu = ALUOPW'(3);
         5'd7:                              alu = ALUOPW'(4);
         5'd8:                              alu = ALUOPW'(5);
         5'd9:                              alu = ALUOPW'(6);
         5'd2, 5'd10, 5'd11, 5'd12, 5'd13:  alu = ALUOPW'(7);
         5'd16, 5'd22:                      alu = ALUOPW'(8);
         5'd17, 5'd23:                      alu = ALUOPW'(9);
         5'd18:                             alu = ALUOPW'(10);
         5'd19:                             alu = ALUOPW'(11);
         5'd20, 5'd21:                      alu = ALUOPW'(12);
         5'd1, 5'd24:                       alu = ALUOPW'(13);
         default:                           legal = 1'b0;
      endcase
      is_div         = legal && lo == 5'd5;
      is_load        = legal && lo == 5'd10;
      is_optr        = legal && lo == 5'd1;
      is_optri       = legal && lo == 5'd24;
      dec.alu_op     = legal ? alu : ALUOPW'(13);
      dec.illegal    = !legal;
      dec.pc_src     = legal && (lo inside {5'd16, 5'd17, 5'd20});
      dec.demux      = is_optr || is_optri;
      dec.optr_inst  = is_optr || is_optri;
      dec.reg_write  = legal && !(lo inside {5'd1, 5'd24, 5'd11, [5'd16:5'd18], [5'd20:5'd23]});
      dec.mem_write  = legal && lo == 5'd11;
      dec.mem_read   = is_load;
      dec.br_or_jump = legal && (lo inside {[5'd16:5'd18], [5'd20:5'd23]});
      dec.mem2reg    = is_load ? 2'd1 : (legal && lo == 5'd12) ? 2'd2 : 2'd0;
   end
   // next state: flush beats stall beats accept beats bubble; WAIT counts down only when not stalled
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ex_valid_d = ex_valid_q;
      ctl_d      = ctl_q;
      alu1_d     = alu1_q;
      if (flush) begin
         state_d    = RUN;
         cnt_d      = '0;
         ex_valid_d = 1'b0;
         ctl_d      = BUB;
      end else if (!stall) begin
         ex_valid_d = accept;
         ctl_d      = accept ? dec : BUB;
         if (state_q == WAIT) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q <= CW'(1)) ? RUN : WAIT;
         end else if (accept) begin
            alu1_d = is_optri ? 1'b0 : is_optr ? 1'b1 : alu1_q;
            if (is_div && DIV_LAT > 1) begin
               state_d = WAIT;
               cnt_d   = CW'(DIV_LAT - 1);
            end else if (is_load && LOAD_LAT > 1) begin
               state_d = WAIT;
               cnt_d   = CW'(LOAD_LAT - 1);
            end
         end
      end
   end
   // state, counter and registered control bundle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         ex_valid_q <= 1'b0;
         alu1_q     <= 1'b0;
         ctl_q      <= BUB;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ex_valid_q <= ex_valid_d;
         alu1_q     <= alu1_d;
         ctl_q      <= ctl_d;
      end
   end
   assign ex_valid    = ex_valid_q;
   assign alu_1st_src = alu1_q;
   assign pc_src      = ctl_q.pc_src;
   assign demux       = ctl_q.demux;
   assign reg_write   = ctl_q.reg_write;
   assign mem_write   = ctl_q.mem_write;
   assign mem_read    = ctl_q.mem_read;
   assign br_or_jump  = ctl_q.br_or_jump;
   assign optr_inst   = ctl_q.optr_inst;
   assign illegal     = ctl_q.illegal;
   assign alu_op      = ctl_q.alu_op;
   assign mem2reg     = ctl_q.mem2reg;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: scoreboard bench with a behavioural decode/hold-off model and random stimulus
module tb_ctrl_decode_stage;
   localparam int OPW = 6, DIV_LAT = 4, LOAD_LAT = 2;
   logic clk = 1'b0, rst = 1'b1;
   logic [OPW-1:0] opcode = '0;
   logic op_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic in_ready, ex_valid, pc_src, demux, reg_write, alu_1st_src;
   logic mem_write, mem_read, br_or_jump, optr_inst, illegal;
   logic [4:0] alu_op;
   logic [1:0] mem2reg;
   int total = 0, passed = 0;
   int busy = 0;
   bit exp_valid = 0, sticky = 0;
   logic [15:0] sb[$];
   logic [15:0] last = '0;
   int alu_tab [25] = '{13,13,7,0,1,2,3,4,5,6,7,7,7,7,0,1,8,9,10,11,12,12,8,9,13};

   ctrl_decode_stage #(.OPW(OPW), .ALUOPW(5), .DIV_LAT(DIV_LAT), .LOAD_LAT(LOAD_LAT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .op_valid(op_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .pc_src(pc_src), .demux(demux),
      .reg_write(reg_write), .alu_1st_src(alu_1st_src), .mem_write(mem_write),
      .mem_read(mem_read), .br_or_jump(br_or_jump), .optr_inst(optr_inst),
      .illegal(illegal), .alu_op(alu_op), .mem2reg(mem2reg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
   endtask

   function automatic logic [15:0] ref_dec(input int op, input bit s);
      bit ok, pc, opt, rw, mw, mr, bj;
      int alu, m2r;
      ok  = op inside {[1:24]};
      alu = (op >= 0 && op <= 24) ? alu_tab[op] : 13;
      pc  = op inside {16, 17, 20};
      opt = op inside {1, 24};
      bj  = op inside {16, 17, 18, 20, 21, 22, 23};
      rw  = ok && !opt && !bj && op != 11;
      mw  = op == 11;
      mr  = op == 10;
      m2r = op == 10 ? 1 : op == 12 ? 2 : 0;
      return {!ok, pc, opt, rw, s, mw, mr, bj, opt, 5'(alu), 2'(m2r)};
   endfunction

   // reference model: advances on each clock edge, resets asynchronously
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         busy = 0;
         exp_valid = 0;
         sticky = 0;
         sb.delete();
      end else if (flush) begin
         busy = 0;
         exp_valid = 0;
      end else if (!stall) begin
         if (busy == 0 && op_valid) begin
            if (int'(opcode) == 1) sticky = 1;
            else if (int'(opcode) == 24) sticky = 0;
            sb.push_back(ref_dec(int'(opcode), sticky));
            exp_valid = 1;
            busy = int'(opcode) == 5 ? DIV_LAT - 1 : int'(opcode) == 10 ? LOAD_LAT - 1 : 0;
         end else begin
            exp_valid = 0;
            if (busy > 0) busy--;
         end
      end
   end

   // monitor: checks ready/valid every cycle and pops the scoreboard when a new bundle appears
   initial forever begin
      @(negedge clk);
      chk("in_ready", 16'(in_ready), 16'(!rst && busy == 0 && !stall && !flush));
      chk("ex_valid", 16'(ex_valid), 16'(exp_valid));
      if (sb.size() > 0) last = sb.pop_front();
      if (ex_valid)
         chk("bundle", {illegal, pc_src, demux, reg_write, alu_1st_src, mem_write, mem_read,
                        br_or_jump, optr_inst, alu_op, mem2reg}, last);
      if (rst)
         chk("reset_bundle", {illegal, pc_src, demux, reg_write, alu_1st_src, mem_write, mem_read,
                              br_or_jump, optr_inst, alu_op, mem2reg}, {9'b0, 5'd13, 2'd0});
   end

   task automatic drive(input bit v, input int op, input bit s, input bit f);
      op_valid = v;
      opcode = OPW'(op);
      stall = s;
      flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drive(1, 3, 0, 0); drive(0, 0, 0, 0);
      drive(1, 24, 0, 0); drive(1, 3, 0, 0); drive(1, 1, 0, 0); drive(1, 3, 0, 0); drive(0, 0, 0, 0);
      drive(1, 5, 0, 0); repeat (4) drive(1, 4, 0, 0); drive(0, 0, 0, 0);
      drive(1, 10, 0, 0); drive(0, 0, 1, 0); drive(0, 0, 1, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      drive(1, 5, 0, 0); drive(0, 0, 0, 1); drive(0, 0, 0, 0);
      drive(1, 5, 0, 0); drive(1, 3, 1, 0); drive(1, 3, 1, 1); drive(1, 3, 0, 0); drive(0, 0, 0, 0);
      drive(1, 31, 0, 0); drive(1, 35, 0, 0); drive(1, 0, 0, 0); drive(0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 250) rst = 1'b1;
         else rst = 1'b0;
         drive($urandom_range(0, 9) < 7,
               $urandom_range(0, 9) == 0 ? $urandom_range(32, 63) : $urandom_range(0, 31),
               $urandom_range(0, 9) < 2, $urandom_range(0, 24) == 0);
      end
      rst = 1'b0;
      repeat (6) drive(0, 0, 0, 0);
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
